// File: rtl/jump_charge_ctrl.sv
// Jump initiator: conditions the raw jump button, charges a launch velocity while
// it is held, and runs the en / v_init handshake with the jump trajectory block.
module jump_charge_ctrl #(
  parameter int V_MIN    = 32,
  parameter int V_STEP   = 2,
  parameter int V_MAX    = 255,
  parameter int DEBOUNCE = 3,
  parameter int TIMEOUT  = 1023
) (
  input  logic        clk_jump,
  input  logic        rst_n,
  input  logic        i_btn,
  input  logic        i_enable,
  input  logic        i_done,
  output logic        o_en,
  output logic [10:0] o_v_init,
  output logic        o_charging,
  output logic        o_landed,
  output logic        o_fault
);
  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CHARGE, JUMP, REARM} state_e;

  state_e          state_q;
  logic            sync1_q;
  logic            sync2_q;
  logic            btn_db_q;
  logic            btn_db_d;
  logic [DB_W-1:0] db_cnt_q;
  logic [DB_W-1:0] db_cnt_d;
  logic [WD_W-1:0] wd_q;
  logic [10:0]     v_q;
  logic [10:0]     v_d;
  logic            en_q;
  logic            charging_q;
  logic            landed_q;
  logic            fault_q;

  // Sum is formed one bit wider than the output so a step past the ceiling can't wrap.
  function automatic logic [10:0] sat_add(input logic [10:0] v);
    logic [11:0] sum;
    logic [10:0] res;
    sum = {1'b0, v} + 12'(V_STEP);
    if (sum > 12'(V_MAX)) res = 11'(V_MAX);
    else                  res = sum[10:0];
    return res;
  endfunction

  always_comb begin
    db_cnt_d = '0;
    btn_db_d = btn_db_q;
    if (sync2_q != btn_db_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE - 1)) btn_db_d = ~btn_db_q;
      else                                 db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign v_d = sat_add(v_q);

  always_ff @(posedge clk_jump or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= i_btn;
      sync2_q  <= sync1_q;
      btn_db_q <= btn_db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  always_ff @(posedge clk_jump or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      v_q        <= '0;
      wd_q       <= '0;
      en_q       <= 1'b0;
      charging_q <= 1'b0;
      landed_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      landed_q <= 1'b0;
      fault_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_db_q && i_enable) begin
            state_q    <= CHARGE;
            v_q        <= 11'(V_MIN);
            charging_q <= 1'b1;
          end
        end
        CHARGE: begin
          // Losing permission takes priority over a release in the same cycle.
          if (!i_enable) begin
            state_q    <= IDLE;
            v_q        <= '0;
            charging_q <= 1'b0;
          end else if (!btn_db_q) begin
            state_q    <= JUMP;
            charging_q <= 1'b0;
            en_q       <= 1'b1;
            wd_q       <= WD_W'(1);
          end else begin
            v_q <= v_d;
          end
        end
        JUMP: begin
          if (i_done || (wd_q == WD_W'(TIMEOUT))) begin
            state_q  <= REARM;
            en_q     <= 1'b0;
            v_q      <= '0;
            wd_q     <= '0;
            landed_q <= i_done;
            fault_q  <= ~i_done;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        REARM: begin
          // Wait for a full release so a press held through landing can't relaunch.
          if (!btn_db_q && !i_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_en       = en_q & rst_n;
  assign o_v_init   = v_q;
  assign o_charging = charging_q;
  assign o_landed   = landed_q;
  assign o_fault    = fault_q;

endmodule

// File: tb/tb_jump_charge_ctrl.sv
// Self-checking bench for jump_charge_ctrl: vector table, directed corner cases and
// random stimulus, all compared every cycle against a behavioural model.
module tb_jump_charge_ctrl;
  localparam int V_MIN    = 32;
  localparam int V_STEP   = 2;
  localparam int V_MAX    = 255;
  localparam int DEBOUNCE = 3;
  localparam int TIMEOUT  = 1023;

  logic        clk_jump = 1'b0;
  logic        rst_n    = 1'b0;
  logic        i_btn    = 1'b0;
  logic        i_enable = 1'b0;
  logic        i_done   = 1'b0;
  logic        o_en;
  logic [10:0] o_v_init;
  logic        o_charging;
  logic        o_landed;
  logic        o_fault;

  always #5 clk_jump = ~clk_jump;

  jump_charge_ctrl #(
    .V_MIN(V_MIN), .V_STEP(V_STEP), .V_MAX(V_MAX), .DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_jump  (clk_jump),
    .rst_n     (rst_n),
    .i_btn     (i_btn),
    .i_enable  (i_enable),
    .i_done    (i_done),
    .o_en      (o_en),
    .o_v_init  (o_v_init),
    .o_charging(o_charging),
    .o_landed  (o_landed),
    .o_fault   (o_fault)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode, number of charge cycles so far, jump cycle count.
  typedef enum {M_IDLE, M_CHARGE, M_JUMP, M_REARM} mode_e;
  mode_e m_mode;
  int    m_n, m_jc, m_vfrozen;
  bit    m_db, m_s1, m_s2, m_landed, m_fault;
  bit    m_hist[$];

  function automatic int charge_v(input int n);
    int v;
    v = V_MIN + V_STEP * (n - 1);
    return (v > V_MAX) ? V_MAX : v;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_n = 0; m_jc = 0; m_vfrozen = 0;
    m_db = 0; m_s1 = 0; m_s2 = 0; m_landed = 0; m_fault = 0;
    m_hist.delete();
  endtask

  task automatic model_step(input bit btn, input bit en, input bit done);
    bit db_old;
    bit all_diff;
    db_old = m_db;
    m_hist.push_back(m_s2);
    if (m_hist.size() > DEBOUNCE) void'(m_hist.pop_front());
    if (m_hist.size() == DEBOUNCE) begin
      all_diff = 1;
      foreach (m_hist[i]) if (m_hist[i] == m_db) all_diff = 0;
      if (all_diff) m_db = !m_db;
    end
    m_s2 = m_s1;
    m_s1 = btn;
    m_landed = 0;
    m_fault  = 0;
    case (m_mode)
      M_IDLE:   if (db_old && en) begin m_mode = M_CHARGE; m_n = 1; end
      M_CHARGE: begin
        if (!en) begin m_mode = M_IDLE; m_n = 0; end
        else if (!db_old) begin m_mode = M_JUMP; m_vfrozen = charge_v(m_n); m_jc = 1; m_n = 0; end
        else m_n++;
      end
      M_JUMP: begin
        if (done) begin m_mode = M_REARM; m_landed = 1; end
        else if (m_jc == TIMEOUT) begin m_mode = M_REARM; m_fault = 1; end
        else m_jc++;
      end
      M_REARM:  if (!db_old && !done) m_mode = M_IDLE;
      default:  m_mode = M_IDLE;
    endcase
  endtask

  int seen_en, seen_chg, chg_cnt, landed_cnt, fault_cnt;

  task automatic tick();
    int exp_v;
    @(posedge clk_jump);
    model_step(i_btn, i_enable, i_done);
    #1;
    exp_v = (m_mode == M_CHARGE) ? charge_v(m_n) : (m_mode == M_JUMP) ? m_vfrozen : 0;
    check("o_en",       o_en,       (m_mode == M_JUMP));
    check("o_charging", o_charging, (m_mode == M_CHARGE));
    check("o_v_init",   o_v_init,   exp_v);
    check("o_landed",   o_landed,   m_landed);
    check("o_fault",    o_fault,    m_fault);
    if (o_en === 1'b1) seen_en++;
    if (o_charging === 1'b1) begin seen_chg++; chg_cnt++; end
    if (o_landed === 1'b1) landed_cnt++;
    if (o_fault === 1'b1) fault_cnt++;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Bounded wait for o_en (sel=1) or o_charging (sel=0) to go high.
  task automatic wait_high(input bit sel, input int budget, input string name);
    int k;
    k = 0;
    while (((sel ? o_en : o_charging) !== 1'b1) && k < budget) begin
      tick();
      k++;
    end
    check(name, sel ? o_en : o_charging, 1);
  endtask

  // Runs the current jump until o_en falls; i_done pulsed on JUMP cycle done_at (0 = never).
  task automatic run_jump(input int done_at, output int en_cycles);
    en_cycles = 1;
    while (o_en === 1'b1 && en_cycles <= TIMEOUT + 5) begin
      if (en_cycles == done_at) i_done = 1'b1;
      tick();
      i_done = 1'b0;
      if (o_en === 1'b1) en_cycles++;
    end
  endtask

  typedef struct {
    int hold;
    int done_at;
    int exp_v;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc;
    vecs[0] = '{hold: 10,  done_at: 300, exp_v: 50};
    vecs[1] = '{hold: 3,   done_at: 5,   exp_v: 36};
    vecs[2] = '{hold: 4,   done_at: 1,   exp_v: 38};
    vecs[3] = '{hold: 112, done_at: 2,   exp_v: 254};
    vecs[4] = '{hold: 113, done_at: 2,   exp_v: 255};
    vecs[5] = '{hold: 200, done_at: 3,   exp_v: 255};

    #1;
    check("rst_o_en",       o_en,       0);
    check("rst_o_v_init",   o_v_init,   0);
    check("rst_o_charging", o_charging, 0);
    check("rst_o_landed",   o_landed,   0);
    check("rst_o_fault",    o_fault,    0);
    #21;
    rst_n = 1'b1;
    model_reset();
    i_enable = 1'b1;
    ticks(3);

    foreach (vecs[i]) begin
      chg_cnt = 0; landed_cnt = 0;
      i_btn = 1'b1;
      ticks(vecs[i].hold);
      i_btn = 1'b0;
      wait_high(1'b1, 20, "vec_en_rise");
      check("vec_v_at_launch", o_v_init, vecs[i].exp_v);
      check("vec_charge_len", chg_cnt, vecs[i].hold);
      run_jump(vecs[i].done_at, cyc);
      check("vec_jump_len", cyc, vecs[i].done_at);
      check("vec_landed", o_landed, 1);
      check("vec_fault", o_fault, 0);
      ticks(3);
      check("vec_landed_once", landed_cnt, 1);
    end

    // Short button glitches never reach the FSM.
    seen_en = 0; seen_chg = 0;
    i_btn = 1'b1; ticks(2); i_btn = 1'b0; ticks(10);
    i_btn = 1'b1; ticks(1); i_btn = 1'b0; ticks(10);
    check("glitch_charging", seen_chg, 0);
    check("glitch_en", seen_en, 0);

    // Enable drops on charge cycle 5.
    seen_en = 0;
    i_btn = 1'b1;
    wait_high(1'b0, 20, "abort_charge_start");
    ticks(4);
    check("abort_v_cycle5", o_v_init, 40);
    i_enable = 1'b0;
    tick();
    check("abort_charging", o_charging, 0);
    check("abort_v", o_v_init, 0);
    ticks(3); i_btn = 1'b0; ticks(10);
    i_enable = 1'b1; ticks(3);
    check("abort_no_en", seen_en, 0);

    // Button held through landing: no relaunch until released and pressed again.
    i_btn = 1'b1; ticks(6); i_btn = 1'b0;
    wait_high(1'b1, 20, "hold_en_rise");
    ticks(4);
    i_btn = 1'b1; ticks(20);
    i_done = 1'b1; tick(); i_done = 1'b0;
    check("hold_landed", o_landed, 1);
    seen_en = 0; seen_chg = 0;
    ticks(30);
    check("hold_no_charge", seen_chg, 0);
    check("hold_no_en", seen_en, 0);
    i_btn = 1'b0; ticks(10);
    i_btn = 1'b1;
    wait_high(1'b0, 20, "hold_recharge");
    i_btn = 1'b0;
    wait_high(1'b1, 20, "hold_relaunch");
    i_done = 1'b1; tick(); i_done = 1'b0; ticks(3);

    // Watchdog abort, then done arriving on the final watchdog cycle.
    fault_cnt = 0; landed_cnt = 0;
    i_btn = 1'b1; ticks(5); i_btn = 1'b0;
    wait_high(1'b1, 20, "to_en_rise");
    run_jump(0, cyc);
    check("to_jump_len", cyc, TIMEOUT);
    check("to_fault", o_fault, 1);
    check("to_landed", o_landed, 0);
    ticks(3);
    check("to_fault_once", fault_cnt, 1);
    fault_cnt = 0; landed_cnt = 0;
    i_btn = 1'b1; ticks(5); i_btn = 1'b0;
    wait_high(1'b1, 20, "tod_en_rise");
    run_jump(TIMEOUT, cyc);
    check("tod_jump_len", cyc, TIMEOUT);
    check("tod_landed", o_landed, 1);
    check("tod_fault", o_fault, 0);
    ticks(3);
    check("tod_no_fault", fault_cnt, 0);

    // Asynchronous reset in the middle of a jump.
    i_btn = 1'b1; ticks(5); i_btn = 1'b0;
    wait_high(1'b1, 20, "ar_en_rise");
    ticks(5);
    #2 rst_n = 1'b0;
    #1;
    check("ar_o_en",       o_en,       0);
    check("ar_o_v_init",   o_v_init,   0);
    check("ar_o_charging", o_charging, 0);
    check("ar_o_landed",   o_landed,   0);
    check("ar_o_fault",    o_fault,    0);
    repeat (2) @(posedge clk_jump);
    #1;
    check("ar_hold_o_en", o_en, 0);
    rst_n = 1'b1;
    model_reset();
    ticks(5);

    // Random stimulus against the model.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) i_btn = ~i_btn;
      if ($urandom_range(0, 59) == 0) i_enable = ~i_enable;
      i_done = ($urandom_range(0, 24) == 0);
      tick();
    end
    i_btn = 1'b0; i_done = 1'b0; i_enable = 1'b1;
    ticks(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jump_charge_ctrl.md
# jump_charge_ctrl

Initiator side of the jump handshake. Converts the player's raw jump button into a charged initial velocity and drives the `en` / `i_v_init` inputs of the `jump` trajectory block. It then holds the jump active until `o_done` returns and re-arms for the next press. It sits between button input conditioning and `jump`, running on the same 192 Hz `clk_jump`.

## Interface
Parameters:
- `V_MIN`, 32: velocity loaded on the first charge cycle.
- `V_STEP`, 2: velocity increment per charge cycle.
- `V_MAX`, 255: saturation ceiling, ≤ 2047.
- `DEBOUNCE`, 3: consecutive stable synchronized samples needed to change the debounced button.
- `TIMEOUT`, 1023: max cycles in JUMP without `i_done` before forced abort.

Ports:
- `clk_jump`  in  1  jump-domain clock (192 Hz).
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_btn`  in  1  raw jump button, asynchronous, active-high.
- `i_enable`  in  1  game state permits a new jump.
- `i_done`  in  1  from `jump.o_done`; landing complete.
- `o_en`  out  1  to `jump.en`; high for the whole jump.
- `o_v_init`  out  11  to `jump.i_v_init`; live charge value, frozen during JUMP.
- `o_charging`  out  1  high in CHARGE (power-bar display).
- `o_landed`  out  1  one-cycle pulse on accepted `i_done`.
- `o_fault`  out  1  one-cycle pulse on timeout abort.

## Operation
- Button path: 2-flop synchronizer feeds a debounce counter. `btn_db` toggles only after the synchronized value differs from `btn_db` for `DEBOUNCE` consecutive cycles. Any mismatch break restarts the count.
- FSM states:
  - IDLE: `o_v_init`=0, `o_en`=0. Goes to CHARGE when `btn_db`=1 and `i_enable`=1.
  - CHARGE: on the entry cycle `v`=`V_MIN`. Each following cycle `v`=min(`v`+`V_STEP`, `V_MAX`), computed in 12 bits then clamped. `o_charging`=1.
    - `btn_db` falls → JUMP.
    - `i_enable` falls (checked first) → IDLE, `v` cleared, no jump.
  - JUMP: `o_en`=1 and `o_v_init` held constant. `i_enable` and the button are ignored.
    - `i_done`=1 → REARM with `o_landed` pulse.
    - Watchdog reaches `TIMEOUT` → REARM with `o_fault` pulse.
  - REARM: `o_en`=0, `v` cleared. Goes to IDLE once `btn_db`=0 and `i_done`=0. A press held through the landing therefore never auto-launches.
- If `i_done`=1 and the timeout land in the same cycle, the done wins: `o_landed`, not `o_fault`.
- `i_done` outside JUMP is ignored.

## Timing
- Reset (async assert, sync-free deassert): FSM=IDLE, `btn_db`=0, debounce/watchdog counters=0. All outputs 0: `o_en`, `o_v_init`, `o_charging`, `o_landed`, `o_fault`.
- Reset mid-jump: `o_en` drops combinationally with `rst_n` low. The downstream `jump` sees `en` fall.
- Press latency: raw edge → `btn_db` rise takes 2 sync + `DEBOUNCE` cycles. CHARGE is entered one cycle later (`o_charging`=1, `o_v_init`=`V_MIN`).
- Charge for N cycles in CHARGE: `o_v_init` = min(`V_MIN` + `V_STEP`·(N−1), `V_MAX`).
- Release: the cycle after `btn_db` falls, state=JUMP, `o_en`=1, `o_v_init` frozen. `o_v_init` is valid on or before the first cycle `o_en` is high.
- `i_done` sampled high in JUMP: the next cycle has `o_en`=0 and `o_landed`=1 for exactly one cycle.
- Watchdog counts JUMP cycles from 1. On the cycle the count equals `TIMEOUT` without `i_done`, the next cycle has `o_en`=0 and `o_fault`=1.
- Minimum gap between two jumps: REARM plus 2 + `DEBOUNCE` + 1 cycles after the button re-press.

## Test plan
- **Nominal charge:** hold `i_btn` so CHARGE lasts 10 cycles, then release; `i_done` after 300 cycles.
  - `o_v_init`=50, `o_en` high from release+1 until `i_done`+1.
  - `o_landed` single pulse; state returns to IDLE.
- **Saturation:** CHARGE held 200 cycles.
  - `o_v_init` climbs 32, 34, … and clamps at 255 from cycle 113 on; no wrap.
- **Glitch rejection:** 2-cycle `i_btn` pulse, then 1-cycle pulse.
  - `o_charging` stays 0 and `o_en` never asserts.
- **Abort and hold-through:**
  - `i_enable` drops on CHARGE cycle 5 → IDLE, `o_v_init`=0, no `o_en`.
  - Separately, keep the button held across `i_done` → no second launch until release and re-press.
- **Timeout:** `i_done` stuck 0 in JUMP.
  - `o_en` falls after exactly 1023 JUMP cycles with one `o_fault` pulse.
  - Repeat with `i_done` arriving on cycle 1023 → `o_landed` only.
- **Async reset mid-jump:** pulse `rst_n` low during JUMP.
  - All outputs 0 immediately with no clock edge; IDLE after release.
